// File: rtl/mem_port_arbiter.sv
// Three-port arbiter in front of the single-ported memory: data (d), fetch (f)
// and external (x). Fixed priority d > f > x with a starvation guard for x.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    input  logic        x_req,
    input  logic        x_we,
    input  logic [2:0]  x_funct3,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    output logic        x_ack,
    output logic [31:0] x_rdata,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [1:0] G_NONE  = 2'b00;
    localparam logic [1:0] G_D     = 2'b01;
    localparam logic [1:0] G_F     = 2'b10;
    localparam logic [1:0] G_X     = 2'b11;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] LAT_LAST = MEM_LATENCY[2:0];
    localparam logic [3:0] SC_LIMIT = STARVE_LIMIT[3:0];

    state_t      state, state_next;
    logic [2:0]  lat_cnt;
    logic [3:0]  sc;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        d_ok, f_ok, x_ok;
    logic [1:0]  winner;
    logic        win_we;
    logic [2:0]  win_funct3;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        arb_en;
    logic        last_cycle;

    // The current owner is excluded while it is being acked in DONE.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        d_ok   = d_req && !(state == S_DONE && grant == G_D);
        f_ok   = f_req && !(state == S_DONE && grant == G_F);
        x_ok   = x_req && !(state == S_DONE && grant == G_X);
        winner = G_NONE;
        if (x_ok && sc == SC_LIMIT) winner = G_X;
        else if (d_ok)              winner = G_D;
        else if (f_ok)              winner = G_F;
        else if (x_ok)              winner = G_X;
    end

    always_comb begin
        win_we     = 1'b0;
        win_funct3 = F3_WORD;
        win_addr   = '0;
        win_wdata  = '0;
        case (winner)
            G_D: begin
                win_we     = d_we;
                win_funct3 = d_funct3;
                win_addr   = d_addr;
                win_wdata  = d_wdata;
            end
            G_F: win_addr = f_addr;
            G_X: begin
                win_we     = x_we;
                win_funct3 = x_funct3;
                win_addr   = x_addr;
                win_wdata  = x_wdata;
            end
            default: ;
        endcase
    end

    assign arb_en     = (state == S_IDLE) || (state == S_DONE);
    assign last_cycle = (state == S_ACCESS) && (we_q || lat_cnt == LAT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (winner != G_NONE) state_next = S_ACCESS;
            S_ACCESS: if (last_cycle) state_next = S_DONE;
            S_DONE:   state_next = (winner != G_NONE) ? S_ACCESS : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            grant            <= G_NONE;
            lat_cnt          <= '0;
            sc               <= '0;
            we_q             <= 1'b0;
            funct3_q         <= F3_WORD;
            addr_q           <= '0;
            wdata_q          <= '0;
            mem_read_address <= '0;
            d_rdata          <= '0;
            f_rdata          <= '0;
            x_rdata          <= '0;
        end else begin
            state <= state_next;
            if (arb_en) begin
                grant   <= winner;
                lat_cnt <= '0;
                if (winner != G_NONE) begin
                    we_q     <= win_we;
                    funct3_q <= win_funct3;
                    addr_q   <= win_addr;
                    wdata_q  <= win_wdata;
                    // Loaded at grant so the read address is stable from the first ACCESS cycle.
                    if (!win_we) mem_read_address <= win_addr;
                end
                if (winner == G_X)
                    sc <= '0;
                else if ((winner == G_D || winner == G_F) && x_req)
                    sc <= sc + 4'd1;
            end else if (state == S_ACCESS) begin
                if (!last_cycle) lat_cnt <= lat_cnt + 3'd1;
                if (!we_q && last_cycle) begin
                    case (grant)
                        G_D:     d_rdata <= mem_read_data;
                        G_F:     f_rdata <= mem_read_data;
                        G_X:     x_rdata <= mem_read_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mem_write_mem     = (state == S_ACCESS) && we_q;
    assign mem_write_address = mem_write_mem ? addr_q  : '0;
    assign mem_write_data    = mem_write_mem ? wdata_q : '0;
    assign mem_funct3        = (state == S_ACCESS) ? funct3_q : F3_WORD;

    assign d_ack = (state == S_DONE) && (grant == G_D);
    assign f_ack = (state == S_DONE) && (grant == G_F);
    assign x_ack = (state == S_DONE) && (grant == G_X);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3, each with a small behavioural memory behind it.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;

    logic        d_req, d_we, f_req, x_req, x_we;
    logic [2:0]  d_funct3, x_funct3;
    logic [31:0] d_addr, d_wdata, f_addr, x_addr, x_wdata;
    logic        d_ack, f_ack, x_ack;
    logic [31:0] d_rdata, f_rdata, x_rdata;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;
    logic [1:0]  grant;
    logic        busy;

    logic        l3_d_req, l3_d_we;
    logic [31:0] l3_d_addr, l3_d_wdata;
    logic        l3_d_ack, l3_f_ack, l3_x_ack;
    logic [31:0] l3_d_rdata, l3_f_rdata, l3_x_rdata;
    logic        l3_mem_write_mem;
    logic [2:0]  l3_mem_funct3;
    logic [31:0] l3_mem_write_address, l3_mem_write_data, l3_mem_read_address, l3_mem_read_data;
    logic [1:0]  l3_grant;
    logic        l3_busy;

    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] rd3_p0, rd3_p1, rd3_p2;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .x_req(x_req), .x_we(x_we), .x_funct3(x_funct3), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_funct3(3'b010), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_ack(l3_d_ack), .d_rdata(l3_d_rdata),
        .f_req(1'b0), .f_addr(32'h0), .f_ack(l3_f_ack), .f_rdata(l3_f_rdata),
        .x_req(1'b0), .x_we(1'b0), .x_funct3(3'b010), .x_addr(32'h0), .x_wdata(32'h0),
        .x_ack(l3_x_ack), .x_rdata(l3_x_rdata),
        .mem_write_mem(l3_mem_write_mem), .mem_funct3(l3_mem_funct3),
        .mem_write_address(l3_mem_write_address), .mem_write_data(l3_mem_write_data),
        .mem_read_address(l3_mem_read_address), .mem_read_data(l3_mem_read_data),
        .grant(l3_grant), .busy(l3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read memory (latency 1) and a three-stage read pipeline (latency 3).
    always @(posedge clk) begin
        if (pl_we) mem1[pl_idx] <= pl_data;
        else if (mem_write_mem) mem1[mem_write_address[9:2]] <= mem_write_data;
        mem_read_data <= mem1[mem_read_address[9:2]];
    end

    always @(posedge clk) begin
        if (pl_we) mem3[pl_idx] <= pl_data;
        else if (l3_mem_write_mem) mem3[l3_mem_write_address[9:2]] <= l3_mem_write_data;
        rd3_p0 <= mem3[l3_mem_read_address[9:2]];
        rd3_p1 <= rd3_p0;
        rd3_p2 <= rd3_p1;
    end
    assign l3_mem_read_data = rd3_p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acks"},   {29'd0, d_ack, f_ack, x_ack}, 32'd0);
        check({tag, "_d_rd"},   d_rdata, 32'd0);
        check({tag, "_f_rd"},   f_rdata, 32'd0);
        check({tag, "_x_rd"},   x_rdata, 32'd0);
        check({tag, "_grant"},  {30'd0, grant}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy}, 32'd0);
        check({tag, "_wmem"},   {31'd0, mem_write_mem}, 32'd0);
        check({tag, "_waddr"},  mem_write_address, 32'd0);
        check({tag, "_wdata"},  mem_write_data, 32'd0);
        check({tag, "_raddr"},  mem_read_address, 32'd0);
        check({tag, "_funct3"}, {29'd0, mem_funct3}, 32'd2);
        check({tag, "_sc"},     {28'd0, u_dut.sc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_grant [1:10];
        logic [2:0] exp_seq [0:4];
        logic [2:0] acks;
        int waited;

        rst_n = 1'b0;
        d_req = 0; d_we = 0; d_funct3 = 3'b010; d_addr = 0; d_wdata = 0;
        f_req = 0; f_addr = 0;
        x_req = 0; x_we = 0; x_funct3 = 3'b010; x_addr = 0; x_wdata = 0;
        l3_d_req = 0; l3_d_we = 0; l3_d_addr = 0; l3_d_wdata = 0;
        pl_we = 0; pl_idx = 0; pl_data = 0;

        step();
        pl_we = 1; pl_idx = 8'h10; pl_data = 32'h0050_0093;
        step();
        pl_idx = 8'h20; pl_data = 32'h1234_5678;
        step();
        pl_we = 0;
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single fetch of 0x40.
        f_req = 1; f_addr = 32'h40;
        step();
        check("fetch_raddr_n1", mem_read_address, 32'h40);
        check("fetch_grant_n1", {30'd0, grant}, 32'd2);
        check("fetch_busy_n1",  {31'd0, busy}, 32'd1);
        check("fetch_ack_n1",   {31'd0, f_ack}, 32'd0);
        step();
        check("fetch_raddr_n2", mem_read_address, 32'h40);
        check("fetch_ack_n2",   {31'd0, f_ack}, 32'd0);
        step();
        check("fetch_ack_n3",   {31'd0, f_ack}, 32'd1);
        check("fetch_rdata",    f_rdata, 32'h0050_0093);
        f_req = 0;
        step();
        check("fetch_idle_busy",  {31'd0, busy}, 32'd0);
        check("fetch_idle_grant", {30'd0, grant}, 32'd0);
        check("fetch_idle_ack",   {31'd0, f_ack}, 32'd0);
        check("fetch_raddr_hold", mem_read_address, 32'h40);

        // Data store followed by a read-back; the read is presented during DONE.
        d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
        step();
        check("store_wmem_n1",  {31'd0, mem_write_mem}, 32'd1);
        check("store_waddr_n1", mem_write_address, 32'h104);
        check("store_wdata_n1", mem_write_data, 32'hDEAD_BEEF);
        check("store_grant_n1", {30'd0, grant}, 32'd1);
        check("store_raddr_n1", mem_read_address, 32'h40);
        step();
        check("store_wmem_n2",  {31'd0, mem_write_mem}, 32'd0);
        check("store_waddr_n2", mem_write_address, 32'd0);
        check("store_ack_n2",   {31'd0, d_ack}, 32'd1);
        d_we = 0;
        step();
        check("owner_ignored_in_done", {31'd0, busy}, 32'd0);
        step();
        check("load_grant", {30'd0, grant}, 32'd1);
        check("load_raddr", mem_read_address, 32'h104);
        step();
        step();
        check("load_ack",   {31'd0, d_ack}, 32'd1);
        check("load_rdata", d_rdata, 32'hDEAD_BEEF);
        check("load_f_rdata_kept", f_rdata, 32'h0050_0093);
        d_req = 0;
        step();

        // Simultaneous d, f, x: serviced d, f, x with no gap.
        exp_grant = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        d_req = 1; d_addr = 32'h40;
        f_req = 1; f_addr = 32'h104;
        x_req = 1; x_we = 0; x_addr = 32'h104;
        for (int i = 1; i <= 10; i++) begin
            step();
            acks = {d_ack, f_ack, x_ack};
            check($sformatf("simul_grant_c%0d", i), {30'd0, grant}, {30'd0, exp_grant[i]});
            check($sformatf("simul_acks_c%0d", i), {29'd0, acks},
                  (i == 3) ? 32'd4 : (i == 6) ? 32'd2 : (i == 9) ? 32'd1 : 32'd0);
            if (d_ack) d_req = 0;
            if (f_ack) f_req = 0;
            if (x_ack) x_req = 0;
        end
        check("simul_d_rdata", d_rdata, 32'h0050_0093);
        check("simul_f_rdata", f_rdata, 32'hDEAD_BEEF);
        check("simul_x_rdata", x_rdata, 32'hDEAD_BEEF);
        check("simul_sc", {28'd0, u_dut.sc}, 32'd0);

        // Starvation: d and f keep requesting; x must win after the 4th d/f grant.
        exp_seq = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b001};
        d_req = 1; d_addr = 32'h40;
        f_req = 1; f_addr = 32'h104;
        x_req = 1; x_addr = 32'h40;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (!(d_ack || f_ack || x_ack) && waited < 10);
            check($sformatf("starve_ack_%0d", k), {29'd0, d_ack, f_ack, x_ack}, {29'd0, exp_seq[k]});
            check($sformatf("starve_gap_%0d", k), waited, 32'd3);
            if (k == 3) check("starve_sc_at_limit", {28'd0, u_dut.sc}, 32'd4);
        end
        d_req = 0; f_req = 0; x_req = 0;
        step();
        check("starve_sc_cleared", {28'd0, u_dut.sc}, 32'd0);
        check("starve_x_rdata", x_rdata, 32'h0050_0093);
        check("starve_idle", {31'd0, busy}, 32'd0);

        // Reset during the second ACCESS cycle of a fetch.
        f_req = 1; f_addr = 32'h40;
        step();
        check("rst_ack_n1", {31'd0, f_ack}, 32'd0);
        step();
        rst_n = 0;
        check("rst_ack_n2", {31'd0, f_ack}, 32'd0);
        step();
        check_reset_outputs("midrst");
        f_req = 0;
        rst_n = 1;
        step();
        check("rst_after_ack",  {31'd0, f_ack}, 32'd0);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        f_req = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("rst_refetch_ack_c%0d", i), {31'd0, f_ack}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("rst_refetch_rdata", f_rdata, 32'h0050_0093);
        f_req = 0;
        step();

        // MEM_LATENCY=3 instance: read acks in N+5, write still in N+2.
        l3_d_req = 1; l3_d_we = 0; l3_d_addr = 32'h80;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("lat3_rd_ack_c%0d", i), {31'd0, l3_d_ack}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("lat3_rd_data", l3_d_rdata, 32'h1234_5678);
        l3_d_req = 0;
        step();
        l3_d_req = 1; l3_d_we = 1; l3_d_addr = 32'h84; l3_d_wdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 2; i++) begin
            step();
            check($sformatf("lat3_wr_wmem_c%0d", i), {31'd0, l3_mem_write_mem}, (i == 1) ? 32'd1 : 32'd0);
            check($sformatf("lat3_wr_ack_c%0d", i), {31'd0, l3_d_ack}, (i == 2) ? 32'd1 : 32'd0);
        end
        l3_d_req = 0;
        step();
        l3_d_req = 1; l3_d_we = 0; l3_d_addr = 32'h84;
        for (int i = 1; i <= 5; i++) step();
        check("lat3_rb_ack",  {31'd0, l3_d_ack}, 32'd1);
        check("lat3_rb_data", l3_d_rdata, 32'hCAFE_F00D);
        l3_d_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-ported `memory` block and shares it among three requesters: the core data path (loads/stores), the instruction fetch path, and an external loader/debug port. It replaces the direct `mem_*` register drives in the core stage sequencer. Each requester uses a req/ack handshake. The arbiter serialises accesses, applies the memory read latency, and returns read data on a per-port registered bus. Grants use fixed priority with a starvation guard for the external port.

## Interface
- `MEM_LATENCY`, default 1: cycles from the first cycle a read address is presented to `mem_read_data` being valid (sync-read memory = 1); legal range 1–7.
- `STARVE_LIMIT`, default 4: consecutive grants lost by a pending `x_req` before it is force-granted; legal range 1–15.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `d_req` in 1, `d_we` in 1, `d_funct3` in 3, `d_addr` in 32, `d_wdata` in 32: data port request.
- `d_ack` out 1, `d_rdata` out 32: data port completion and read data.
- `f_req` in 1, `f_addr` in 32: fetch port request; always a word read (funct3 = 3'b010).
- `f_ack` out 1, `f_rdata` out 32: fetch port completion and read data.
- `x_req` in 1, `x_we` in 1, `x_funct3` in 3, `x_addr` in 32, `x_wdata` in 32: external port request.
- `x_ack` out 1, `x_rdata` out 32: external port completion and read data.
- `mem_write_mem` out 1, `mem_funct3` out 3, `mem_write_address` out 32, `mem_write_data` out 32, `mem_read_address` out 32: drives to `memory`.
- `mem_read_data` in 32: read data from `memory`.
- `grant` out 2: current owner. 00 = none, 01 = d, 10 = f, 11 = x.
- `busy` out 1: high in ACCESS and DONE.

## Operation
- **Request rules**
  - A requester holds req and its payload stable until it sees ack.
  - In the cycle after ack, the requester drops req or presents a new request.
- **States**
  - IDLE: no transfer in progress. Arbitrate. If any req is present, latch the winner, its payload, and `grant`, then go to ACCESS.
  - ACCESS, write: lasts exactly 1 cycle. `mem_write_mem`=1, `mem_write_address`=addr, `mem_write_data`=wdata, `mem_funct3`=funct3. Then go to DONE.
  - ACCESS, read: lasts MEM_LATENCY+1 cycles, counted by a 3-bit counter. `mem_read_address`=addr and `mem_funct3`=funct3 are held throughout. `mem_read_data` is captured into the owner's rdata register at the end of the last ACCESS cycle. Then go to DONE.
  - DONE: 1 cycle. The owner's ack=1, and its rdata is valid (for reads). Arbitrate among the non-owner ports only; the owner's req is ignored this cycle. If a winner exists, go to ACCESS with the new grant; otherwise go to IDLE with `grant`=00.
- **Priority**
  - Default order: d > f > x.
  - Starvation counter `sc` (4-bit):
    - Increments on each grant to d or f while `x_req`=1.
    - Clears on a grant to x.
    - Holds otherwise.
  - When `sc`==STARVE_LIMIT and `x_req`=1, x wins the arbitration.
- **Memory output defaults**
  - Outside a write ACCESS: `mem_write_mem`=0, `mem_write_address`=0, `mem_write_data`=0.
  - `mem_read_address` holds its last value except in read ACCESS.
  - `mem_funct3` returns to 3'b010 in IDLE.
- **Read data**
  - rdata registers keep their last captured value.
  - Only the owner's rdata register is updated.
- **Checks not performed here:** the arbiter does no address decode or alignment checks; `memory` handles those.

## Timing
- **Reset values:** all acks 0, all rdata 0, `grant`=00, `busy`=0, `mem_write_mem`=0, all `mem_*` address/data 0, `mem_funct3`=3'b010, state IDLE, `sc`=0, latency counter 0.
- **Read latency**, req first high in IDLE cycle N:
  - ACCESS runs cycles N+1 … N+1+MEM_LATENCY.
  - ack is in cycle N+2+MEM_LATENCY (N+3 for the default).
- **Write latency**, req first high in IDLE cycle N:
  - `mem_write_mem`=1 only in N+1.
  - ack in N+2.
- **Back-to-back:** a pending request from another port starts ACCESS the cycle after DONE, with no IDLE gap.
- **Ack width:** ack is a single-cycle pulse; at most one ack is high in any cycle.
- **Reset mid-operation:** from the cycle after `rst_n` is sampled low, the block takes its reset values. A write whose `mem_write_mem` cycle coincides with reset sampling still commits. No ack is issued for an aborted transfer.
- **Request withdrawal:** a req dropped before its grant is simply not served; it has no effect on `sc` beyond grants already counted.

## Test plan
- **Single fetch:** f_req=1, f_addr=0x40, memory word 0x00500093 → `mem_read_address`=0x40 in N+1..N+2; f_ack=1 and f_rdata=0x00500093 in N+3; `grant`=10 during busy.
- **Data store:** d_req, d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF, d_funct3=010 → `mem_write_mem`=1 for exactly one cycle (N+1) with matching address/data; d_ack in N+2; then a d read of 0x104 returns 0xDEADBEEF.
- **Simultaneous requests:** d, f, x all high in cycle N → serviced in order d, f, x with no idle cycles between DONE and ACCESS; exactly one ack per transfer.
- **Starvation:** x_req held while d and f alternate continuously, STARVE_LIMIT=4 → x is granted immediately after the 4th d/f grant; `sc` reads 0 afterwards.
- **Reset mid-read:** `rst_n` low during the second ACCESS cycle of a fetch → next cycle all outputs are at reset values; f_ack never pulses; a new f_req after reset completes normally.
- **Latency parameter:** MEM_LATENCY=3 with a memory model of 3-cycle read → ack in N+5 with correct data; writes still ack in N+2.
